carfield_boot_sequencer: RTL



---
 rtl/carfield_boot_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/carfield_boot_sequencer.sv
// Boot sequencer for the Carfield host and security island.
// Preloads or autonomously boots, wakes the security island, then polls the host for end-of-computation.
module carfield_boot_sequencer #(
  parameter logic [31:0] SecdWakeAddr = 32'h2000_0004,
  parameter logic [31:0] SecdBootAddr = 32'hE000_0080,
  parameter logic [31:0] EocAddr      = 32'h0300_0008,
  parameter int unsigned PollInterval = 16,
  parameter int unsigned MaxPolls     = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  boot_mode_i,
  input  logic        secd_en_i,
  input  logic        preload_done_i,
  output logic        secd_rst_o,
  output logic        host_rst_o,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] exit_code_o
);

  // state       | meaning
  // S_IDLE      | waiting for start_i
  // S_PRELOAD   | external preload engine running
  // S_WAKE_REQ  | entry-point write to security island, waiting for grant
  // S_WAKE_RSP  | entry-point write granted, waiting for response
  // S_POLL_WAIT | idle gap between EOC polls (down-counter)
  // S_POLL_REQ  | EOC read, waiting for grant
  // S_POLL_RSP  | EOC read granted, waiting for response
  // S_DONE      | host reported end-of-computation (terminal)
  // S_ERR       | unsupported mode or poll timeout (terminal)
  typedef enum logic [3:0] {
    S_IDLE, S_PRELOAD, S_WAKE_REQ, S_WAKE_RSP, S_POLL_WAIT,
    S_POLL_REQ, S_POLL_RSP, S_DONE, S_ERR
  } state_e;

  localparam logic [15:0] WaitReload = 16'(PollInterval - 1);
  localparam logic [15:0] PollLimit  = 16'(MaxPolls);

  state_e      state_q, state_d;
  logic        secd_en_q;
  logic        secd_rst_q, host_rst_q;
  logic [31:0] exit_code_q;
  logic [15:0] wait_cnt_q;
  logic [15:0] poll_cnt_q;

  logic        secd_en_we, host_rst_clr, secd_rst_clr, exit_we, poll_inc;
  logic [31:0] exit_d;

  always_comb begin
    state_d      = state_q;
    secd_en_we   = 1'b0;
    host_rst_clr = 1'b0;
    secd_rst_clr = 1'b0;
    exit_we      = 1'b0;
    exit_d       = '0;
    poll_inc     = 1'b0;
    req_o        = 1'b0;
    we_o         = 1'b0;
    addr_o       = '0;
    wdata_o      = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          secd_en_we = 1'b1;
          case (boot_mode_i)
            2'd0: state_d = S_PRELOAD;
            2'd1: begin
              state_d = S_ERR;
              exit_we = 1'b1;
              exit_d  = 32'hFFFF_FFFE;
            end
            default: begin
              state_d      = S_POLL_WAIT;
              host_rst_clr = 1'b1;
            end
          endcase
        end
      end
      S_PRELOAD: begin
        if (preload_done_i) begin
          if (secd_en_q) begin
            state_d = S_WAKE_REQ;
          end else begin
            state_d      = S_POLL_WAIT;
            host_rst_clr = 1'b1;
          end
        end
      end
      S_WAKE_REQ: begin
        req_o   = 1'b1;
        we_o    = 1'b1;
        addr_o  = SecdWakeAddr;
        wdata_o = SecdBootAddr;
        if (gnt_i) state_d = S_WAKE_RSP;
      end
      S_WAKE_RSP: begin
        if (rvalid_i) begin
          secd_rst_clr = 1'b1;
          host_rst_clr = 1'b1;
          state_d      = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: begin
        if (wait_cnt_q == '0) state_d = S_POLL_REQ;
      end
      S_POLL_REQ: begin
        req_o  = 1'b1;
        addr_o = EocAddr;
        if (gnt_i) begin
          poll_inc = 1'b1;
          state_d  = S_POLL_RSP;
        end
      end
      S_POLL_RSP: begin
        // poll_cnt_q already counts the read whose response is arriving
        if (rvalid_i) begin
          if (rdata_i[0]) begin
            state_d = S_DONE;
            exit_we = 1'b1;
            exit_d  = {1'b0, rdata_i[31:1]};
          end else if (poll_cnt_q == PollLimit) begin
            state_d = S_ERR;
            exit_we = 1'b1;
            exit_d  = 32'hFFFF_FFFF;
          end else begin
            state_d = S_POLL_WAIT;
          end
        end
      end
      S_DONE, S_ERR: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      secd_en_q   <= 1'b0;
      secd_rst_q  <= 1'b1;
      host_rst_q  <= 1'b1;
      exit_code_q <= '0;
      wait_cnt_q  <= '0;
      poll_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (secd_en_we)   secd_en_q   <= secd_en_i;
      if (secd_rst_clr) secd_rst_q  <= 1'b0;
      if (host_rst_clr) host_rst_q  <= 1'b0;
      if (exit_we)      exit_code_q <= exit_d;
      if (poll_inc)     poll_cnt_q  <= poll_cnt_q + 16'd1;
      if (state_d == S_POLL_WAIT && state_q != S_POLL_WAIT) begin
        wait_cnt_q <= WaitReload;
      end else if (state_q == S_POLL_WAIT && wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - 16'd1;
      end
    end
  end

  assign secd_rst_o  = secd_rst_q;
  assign host_rst_o  = host_rst_q;
  assign exit_code_o = exit_code_q;
  assign busy_o      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done_o      = (state_q == S_DONE);
  assign err_o       = (state_q == S_ERR);

endmodule
